// File: rtl/pipeline_pkg.sv
// Shared constants for the instruction prefetch stage: data width,
// sequential PC step and the fetch FSM state encoding.
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_IDLE    = 2'd0;
    localparam fetch_state_t S_WAIT    = 2'd1;
    localparam fetch_state_t S_DISCARD = 2'd2;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// prefetch_fifo: synchronous DEPTH-entry in-order queue with push/pop/clear
// and an occupancy count; clear wins over push and pop in the same cycle.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_ok;

    assign pop_ok = pop && (count != '0);
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch stage: one outstanding fetch into an in-order queue
// feeding IF/ID. Optional statistics counters under PREFETCH_STATS_EN.
//
// state     | meaning
// S_IDLE    | no fetch in flight; may request when queue space remains
// S_WAIT    | fetch granted, response will be enqueued
// S_DISCARD | fetch granted before a redirect, response will be dropped
module instr_prefetch_queue
    import pipeline_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc_plus4
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]     stat_drop_cnt,
    output logic [15:0]     stat_starve_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t        state;
    logic [XLEN-1:0]     fetch_pc;
    logic [XLEN-1:0]     issued_pc;
    logic [CW-1:0]       count;
    logic [2*XLEN-1:0]   head;
    logic                grant;
    logic                push;
    logic                pop;

    // Only one fetch is ever outstanding and it is only issued from IDLE,
    // so count < DEPTH is enough to reserve a slot for its response.
    assign imem_req  = rst_n && (state == S_IDLE) && (count < DEPTH_C) && !redirect;
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;
    assign push      = (state == S_WAIT) && imem_rvalid && !redirect;
    assign pop       = out_valid && out_ready && !redirect;

    assign out_valid    = (count != '0);
    assign out_instr    = head[2*XLEN-1:XLEN];
    assign out_pc_plus4 = head[XLEN-1:0];

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .wdata ({imem_rdata, issued_pc + PC_INC}),
        .rdata (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            issued_pc <= RESET_PC;
        end else begin
            case (state)
                S_IDLE:    if (grant) state <= S_WAIT;
                // A response coinciding with a redirect is consumed and dropped
                // here; waiting in DISCARD for it would never terminate.
                S_WAIT:    if (imem_rvalid) state <= S_IDLE;
                           else if (redirect) state <= S_DISCARD;
                S_DISCARD: if (imem_rvalid) state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase

            if (redirect) fetch_pc <= redirect_pc;
            else if (grant) fetch_pc <= fetch_pc + PC_INC;

            if (grant) issued_pc <= fetch_pc;
        end
    end

`ifdef PREFETCH_STATS_EN
    logic drop_evt;
    logic starve_evt;

    assign drop_evt   = imem_rvalid && ((state == S_DISCARD) || ((state == S_WAIT) && redirect));
    assign starve_evt = out_ready && !out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_drop_cnt   <= '0;
            stat_starve_cnt <= '0;
        end else begin
            if (drop_evt && (stat_drop_cnt != 16'hFFFF))
                stat_drop_cnt <= stat_drop_cnt + 16'd1;
            if (starve_evt && (stat_starve_cnt != 16'hFFFF))
                stat_starve_cnt <= stat_starve_cnt + 16'd1;
        end
    end
`endif

endmodule
